// File: rtl/inv_mix_columns_seq_if.sv
// Handshake/data bundle for the iterative InvMixColumns block.
//   enable    : start request (master -> slave)
//   state     : 128-bit input state, column 0 in [127:96] (master -> slave)
//   state_out : 128-bit transformed state, held between completions (slave -> master)
//   done      : one-cycle completion pulse (slave -> master)
//   busy      : transform in progress (slave -> master)
interface inv_mix_columns_seq_if;
  logic         enable;
  logic [127:0] state;
  logic [127:0] state_out;
  logic         done;
  logic         busy;

  modport master (
    output enable,
    output state,
    input  state_out,
    input  done,
    input  busy
  );

  modport slave (
    input  enable,
    input  state,
    output state_out,
    output done,
    output busy
  );
endinterface

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: multiplies each 32-bit state column by the
// circulant matrix {0e 0b 0d 09} over GF(2^8), COLS_PER_CYCLE columns per clock.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of inv_mix_columns_seq_if (enable/state in,
//         state_out/done/busy out)
module inv_mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  inv_mix_columns_seq_if.slave bus
);

  localparam int unsigned NUM_COLS = 4;
  // For four columns per cycle the step wraps to 0, which keeps col at 0.
  localparam logic [1:0]  COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0]  LAST_COL = 2'(NUM_COLS - COLS_PER_CYCLE);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
      $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  // Column c lives at index 3-c so the packed view matches the 128-bit layout.
  fsm_t             fsm;
  logic [1:0]       col;
  logic [3:0][31:0] work;
  logic [3:0][31:0] result;
  logic [3:0][31:0] res_next;
  logic [3:0][31:0] out_q;
  logic             done_q;
  logic             busy_q;
  logic [1:0]       idx;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the inverse matrix using the shared x2/x4/x8 chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [3:0][7:0] a;
    logic [3:0][7:0] x2;
    logic [3:0][7:0] x4;
    logic [3:0][7:0] x8;
    logic [3:0][7:0] m9;
    logic [3:0][7:0] mb;
    logic [3:0][7:0] md;
    logic [3:0][7:0] me;
    logic [7:0]      b0;
    logic [7:0]      b1;
    logic [7:0]      b2;
    logic [7:0]      b3;
    // a[3] is row 0 (bits 31:24)
    a = w;
    for (int i = 0; i < 4; i++) begin
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    b0 = me[3] ^ mb[2] ^ md[1] ^ m9[0];
    b1 = m9[3] ^ me[2] ^ mb[1] ^ md[0];
    b2 = md[3] ^ m9[2] ^ me[1] ^ mb[0];
    b3 = mb[3] ^ md[2] ^ m9[1] ^ me[0];
    return {b0, b1, b2, b3};
  endfunction

  // Merge the columns handled this cycle into the partial result.
  always_comb begin
    res_next = result;
    idx      = col;
    for (int k = 0; k < int'(COLS_PER_CYCLE); k++) begin
      idx           = col + 2'(k);
      res_next[~idx] = inv_mix_col(work[~idx]);
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm    <= IDLE;
      col    <= 2'd0;
      work   <= '0;
      result <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm)
        IDLE: begin
          if (bus.enable) begin
            work   <= bus.state;
            col    <= 2'd0;
            busy_q <= 1'b1;
            fsm    <= RUN;
          end
        end
        RUN: begin
          result <= res_next;
          col    <= col + COL_STEP;
          if (col == LAST_COL) begin
            out_q  <= res_next;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            fsm    <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.state_out = out_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: runs COLS_PER_CYCLE = 1, 2 and 4 side by side
// on shared stimulus and checks them against a generic GF(2^8) matrix model.
module tb_inv_mix_columns_seq;

  logic         clk;
  logic         rst;
  logic         en;
  logic [127:0] st_in;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;

  inv_mix_columns_seq_if bus1 ();
  inv_mix_columns_seq_if bus2 ();
  inv_mix_columns_seq_if bus4 ();

  assign bus1.enable = en;
  assign bus1.state  = st_in;
  assign bus2.enable = en;
  assign bus2.state  = st_in;
  assign bus4.enable = en;
  assign bus4.state  = st_in;

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  logic [127:0] obs_out  [3];
  logic         obs_done [3];
  logic         obs_busy [3];
  assign obs_out[0]  = bus1.state_out;
  assign obs_out[1]  = bus2.state_out;
  assign obs_out[2]  = bus4.state_out;
  assign obs_done[0] = bus1.done;
  assign obs_done[1] = bus2.done;
  assign obs_done[2] = bus4.done;
  assign obs_busy[0] = bus1.busy;
  assign obs_busy[1] = bus2.busy;
  assign obs_busy[2] = bus4.busy;

  int           lat  [3];
  int           cpc  [3];
  logic [127:0] prev [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // Circulant matrix coefficient at diagonal offset d.
  function automatic logic [7:0] coef(input bit inv, input int d);
    logic [7:0] c;
    case (d)
      0:       c = inv ? 8'h0e : 8'h02;
      1:       c = inv ? 8'h0b : 8'h03;
      2:       c = inv ? 8'h0d : 8'h01;
      default: c = inv ? 8'h09 : 8'h01;
    endcase
    return c;
  endfunction

  function automatic logic [127:0] mix_state(input logic [127:0] s, input bit inv);
    logic [15:0][7:0] bi;
    logic [15:0][7:0] bo;
    logic [7:0]       acc;
    bi = s;
    bo = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef(inv, (k - r + 4) % 4), bi[4'(15 - 4 * c - k)]);
        bo[4'(15 - 4 * c - r)] = acc;
      end
    end
    return bo;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int inst, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [cols=%0d] t=%0t: got %h, expected %h", name, cpc[inst], $time, act, exp);
    end
  endtask

  task automatic chk_idle_reset();
    for (int i = 0; i < 3; i++) begin
      chk("reset_state_out", i, obs_out[i], 128'h0);
      chk("reset_busy", i, 128'(obs_busy[i]), 128'h0);
      chk("reset_done", i, 128'(obs_done[i]), 128'h0);
    end
  endtask

  // Called at a negedge with all instances idle: one-cycle enable, then
  // checks busy/done/state_out timing for each latency over five samples.
  task automatic transact(input logic [127:0] s, input logic [127:0] exp);
    en    = 1'b1;
    st_in = s;
    @(posedge clk);
    @(negedge clk);
    en    = 1'b0;
    st_in = rand128();
    for (int t = 0; t <= 4; t++) begin
      for (int i = 0; i < 3; i++) begin
        chk("busy", i, 128'(obs_busy[i]), 128'(t < lat[i]));
        chk("done", i, 128'(obs_done[i]), 128'(t == lat[i]));
        chk("state_out", i, obs_out[i], (t >= lat[i]) ? exp : prev[i]);
      end
      if (t < 4) @(negedge clk);
    end
    for (int i = 0; i < 3; i++) prev[i] = exp;
  endtask

  typedef struct {
    logic [127:0] s;
    logic [127:0] e;
  } vec_t;

  vec_t         vecs [4];
  logic [127:0] inputs [13];
  logic [127:0] cur [3];
  logic [127:0] s;
  int           m;

  initial begin
    lat = '{4, 2, 1};
    cpc = '{1, 2, 4};
    for (int i = 0; i < 3; i++) prev[i] = '0;

    vecs[0] = '{s: FIPS_IN,            e: FIPS_OUT};
    vecs[1] = '{s: {16{8'hc6}},        e: {16{8'hc6}}};
    vecs[2] = '{s: {16{8'h01}},        e: {16{8'h01}}};
    vecs[3] = '{s: 128'h0,             e: 128'h0};

    rst   = 1'b1;
    en    = 1'b0;
    st_in = '0;
    @(negedge clk);
    chk_idle_reset();
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors.
    for (int v = 0; v < 4; v++) transact(vecs[v].s, vecs[v].e);

    // Enable held high with a new state every cycle: accepts every L+1 edges.
    en        = 1'b1;
    st_in     = FIPS_IN;
    inputs[0] = FIPS_IN;
    for (int i = 0; i < 3; i++) cur[i] = prev[i];
    @(posedge clk);
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        m = t % (lat[i] + 1);
        if (m == lat[i]) cur[i] = mix_state(inputs[t - lat[i]], 1'b1);
        chk("hold_busy", i, 128'(obs_busy[i]), 128'(m < lat[i]));
        chk("hold_done", i, 128'(obs_done[i]), 128'(m == lat[i]));
        chk("hold_state_out", i, obs_out[i], cur[i]);
      end
      st_in         = rand128();
      inputs[t + 1] = st_in;
    end
    en = 1'b0;
    repeat (6) @(negedge clk);

    // Reset two cycles after accept aborts the single-column instance.
    en    = 1'b1;
    st_in = FIPS_IN;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    chk("abort_done_pre", 0, 128'(obs_done[0]), 128'h0);
    @(negedge clk);
    chk("abort_done_pre", 0, 128'(obs_done[0]), 128'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_idle_reset();
    @(negedge clk);
    chk_idle_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) prev[i] = '0;
    transact(FIPS_IN, FIPS_OUT);

    // Round trip through the forward MixColumns model.
    for (int n = 0; n < 1000; n++) begin
      s = rand128();
      transact(mix_state(s, 1'b0), s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
